xdisplay_ctrl: RTL and testbench
================================

// Module: xdisplay_ctrl
//
// PURPOSE
// Four-digit 7-segment display controller on the external peripheral bus. It is downstream of the external address decoder.
// - It consumes the decoder's one-hot display_sel[3:0] write strobes and the CPU write data.
// - It latches one hex digit per display position.
// - It time-multiplexes the digits onto shared active-low segment and anode pins for the MemoryGame board.
//
// PARAMETERS
// DATA_W       32      CPU write-data width; only bits [5:0] are used
// REFRESH_DIV  100000  clk cycles per digit slot; legal range >= 2
// BLINK_TICKS  64      refresh ticks per blink half-period; used only when XDISPLAY_BLINK_EN is defined
//
// PORTS
// clk        in   1       system clock
// rst        in   1       synchronous reset, active-high
// sel        in   4       one-hot write strobe per digit (decoder display_sel)
// data_in    in   DATA_W  write data: [3:0] hex value, [4] blank, [5] blink
// seg        out  7       segments {g,f,e,d,c,b,a}, active-low, registered
// an         out  4       digit anodes, active-low, registered
// busy       out  1       1 while the blink phase is in its "off" half
//
// BEHAVIOUR
// - Interface: one clock; reset is synchronous and active-high.
// - Reset:
//   - digit regs = {blank=1, val=0};
//   - refresh counter = 0, digit index = 0, blink phase = 0;
//   - seg = 7'h7F, an = 4'b1111, busy = 0.
// - Write:
//   - Each set bit of sel writes data_in[4:0] into that digit register on the same clk edge.
//   - Several sel bits set together write every selected digit with the same data.
//   - sel = 0 means no change.
// - Refresh counter:
//   - Counts 0..REFRESH_DIV-1, then wraps to 0.
//   - The wrap cycle is a "tick". On a tick, the index advances 0->1->2->3->0.
// - Output register (updates every cycle from the current index and digit register):
//   - an = ~(4'b0001 << index).
//   - seg = 7'h7F if the digit is blank, else hex_decode(val).
//   - Latency: a write to the displayed digit appears on seg 1 cycle later (write edge, then output edge).
//   - A tick moves an/seg to the next digit 1 cycle after the tick.
// - Hex decode, active-low {g..a}:
//   - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000,
//   - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000,
//   - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011,
//   - C = 1000110, d = 0100001, E = 0000110, F = 0001110.
// - Write and tick in the same cycle: the write lands, the index advances, and the output shows the new index's register.
// - Reset asserted mid-scan: on the next edge, everything returns to reset values. The scan restarts at digit 0, with an = 4'b1110 on the first cycle after rst drops.
// - busy is always 0 without the blink feature.
//
// CONFIGURATION
// XDISPLAY_BLINK_EN defined:
// - data_in[5] is stored as a per-digit blink flag.
// - A tick counter toggles the blink phase every BLINK_TICKS ticks.
// - While the phase = 1, digits with blink = 1 output seg = 7'h7F; the anode is still driven. busy = phase.
// - Reset clears all blink flags and the phase.
// XDISPLAY_BLINK_EN undefined:
// - data_in[5] is ignored and not stored; there is no blink counter; busy is tied to 0.
//
// TESTING (bench: REFRESH_DIV=4, BLINK_TICKS=2)
// 1. Release rst. Expect an = 1110 and seg = 7F after 1 cycle, then an cycling 1101, 1011, 0111, 1110 every 4 clk.
// 2. Write sel = 0001 with data 0x8. While an = 1110: seg = 0000000 on the next edge. Other slots stay 7F.
// 3. Write sel = 1111 with data 0xA. All four slots show seg = 0001000. Then write sel = 0100 with data 0x10 (blank): slot 2 shows 7F, the others stay 0001000.
// 4. Assert the write to the currently displayed digit on the same cycle as the tick. The new index's value is shown, and the written value is visible when its slot returns.
// 5. Assert rst for 1 cycle mid-scan with digits loaded. seg = 7F and an = 1111 during reset, all digits blank afterwards, and the scan restarts at digit 0.
// 6. [XDISPLAY_BLINK_EN] Write sel = 0010 with data 0x23 (val 3, blink). Slot 1 alternates 0110000 and 7F every 2 ticks, and busy tracks the phase. Without the macro, slot 1 shows 0110000 steadily and busy = 0.

Source files
------------

// File: rtl/xdisplay_ctrl_if.sv
// Write-side bus from the external address decoder into the display controller:
// one-hot digit strobes plus CPU write data.
interface xdisplay_ctrl_if #(
   parameter int DATA_W = 32
);
   logic [3:0]        sel;
   logic [DATA_W-1:0] data_in;

   modport master (output sel, output data_in);
   modport slave  (input  sel, input  data_in);
endinterface

// File: rtl/xdisplay_ctrl.sv
// Four-digit multiplexed 7-segment controller with active-low seg/an pins.
// Optional per-digit blink is enabled by defining XDISPLAY_BLINK_EN.
module xdisplay_ctrl #(
   parameter int DATA_W      = 32,
   parameter int REFRESH_DIV = 100000,
   parameter int BLINK_TICKS = 64
) (
   input  logic           clk,
   input  logic           rst,
   xdisplay_ctrl_if.slave bus,
   output logic [6:0]     seg,
   output logic [3:0]     an,
   output logic           busy
);

   localparam int              CNT_W    = $clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick;
   logic [1:0]       idx_q, idx_d;
   logic [3:0][3:0]  val_q, val_d;
   logic [3:0]       blank_q, blank_d;
   logic [6:0]       seg_q, seg_d;
   logic [3:0]       an_q, an_d;
   logic             digit_off;

   function automatic logic [6:0] hex_decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0:    s = 7'b1000000;
         4'h1:    s = 7'b1111001;
         4'h2:    s = 7'b0100100;
         4'h3:    s = 7'b0110000;
         4'h4:    s = 7'b0011001;
         4'h5:    s = 7'b0010010;
         4'h6:    s = 7'b0000010;
         4'h7:    s = 7'b1111000;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0010000;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b0000011;
         4'hC:    s = 7'b1000110;
         4'hD:    s = 7'b0100001;
         4'hE:    s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   always_comb begin
      val_d   = val_q;
      blank_d = blank_q;
      for (int i = 0; i < 4; i++) begin
         if (bus.sel[i]) begin
            val_d[i]   = bus.data_in[3:0];
            blank_d[i] = bus.data_in[4];
         end
      end
   end

   always_comb begin
      tick  = (cnt_q == CNT_LAST);
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
      idx_d = idx_q + {1'b0, tick};
   end

   // Output stage reads the registered digit, so a write shows one edge later.
   always_comb begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = digit_off ? 7'h7F : hex_decode(val_q[idx_q]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         idx_q   <= '0;
         val_q   <= '0;
         blank_q <= 4'hF;
         seg_q   <= 7'h7F;
         an_q    <= 4'hF;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         val_q   <= val_d;
         blank_q <= blank_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
      end
   end

   assign seg = seg_q;
   assign an  = an_q;

`ifdef XDISPLAY_BLINK_EN
   localparam int               BCNT_W    = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLINK_TICKS - 1);

   logic [3:0]        blink_q, blink_d;
   logic [BCNT_W-1:0] bcnt_q, bcnt_d;
   logic              phase_q, phase_d;
   logic              busy_q, busy_d;
   logic              unused_data;

   always_comb begin
      blink_d = blink_q;
      for (int i = 0; i < 4; i++) begin
         if (bus.sel[i]) blink_d[i] = bus.data_in[5];
      end
   end

   always_comb begin
      bcnt_d  = bcnt_q;
      phase_d = phase_q;
      if (tick) begin
         if (bcnt_q == BCNT_LAST) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
         end else begin
            bcnt_d = bcnt_q + BCNT_W'(1);
         end
      end
   end

   // busy is delayed to line up with the seg register that it qualifies.
   always_comb begin
      busy_d    = phase_q;
      digit_off = blank_q[idx_q] | (phase_q & blink_q[idx_q]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         blink_q <= '0;
         bcnt_q  <= '0;
         phase_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         blink_q <= blink_d;
         bcnt_q  <= bcnt_d;
         phase_q <= phase_d;
         busy_q  <= busy_d;
      end
   end

   assign busy        = busy_q;
   assign unused_data = ^bus.data_in[DATA_W-1:6];
`else
   logic unused_data;

   always_comb begin
      digit_off = blank_q[idx_q];
   end

   assign busy        = 1'b0;
   assign unused_data = ^bus.data_in[DATA_W-1:5];
`endif

endmodule

// File: tb/tb_xdisplay_ctrl.sv
// Scoreboard bench for xdisplay_ctrl: expected pin values are queued at the
// driving negedge and popped just after the following posedge.
module tb_xdisplay_ctrl;

   localparam int RD = 4;
   localparam int BT = 2;
   localparam int DW = 32;

   localparam logic [6:0] HEX [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   typedef struct packed {
      logic [6:0] seg;
      logic [3:0] an;
      logic       busy;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] seg;
   logic [3:0] an;
   logic       busy;

   xdisplay_ctrl_if #(.DATA_W(DW)) bus ();

   xdisplay_ctrl #(
      .DATA_W(DW),
      .REFRESH_DIV(RD),
      .BLINK_TICKS(BT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus),
      .seg(seg),
      .an(an),
      .busy(busy)
   );

   always #5 clk = ~clk;

   exp_t       exp_q[$];
   exp_t       mon_e;
   int         n_checks = 0;
   int         n_fail   = 0;
   int         edge_k   = 0;
   logic [3:0] m_val  [4];
   logic       m_blank[4];
   logic       m_blink[4];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_val[i]   = 4'h0;
         m_blank[i] = 1'b1;
         m_blink[i] = 1'b0;
      end
      edge_k = 0;
   endtask

   // One clock of stimulus; the expectation for the coming edge comes from the
   // cycle position since reset release and the bench's own digit copy.
   task automatic cyc(input logic r, input logic [3:0] s, input logic [5:0] d);
      exp_t e;
      int   k, idx, ph;
      logic off;
      @(negedge clk);
      rst         = r;
      bus.sel     = s;
      bus.data_in = {{(DW-6){1'b0}}, d};
      if (r) begin
         e.seg  = 7'h7F;
         e.an   = 4'hF;
         e.busy = 1'b0;
         model_reset();
      end else begin
         k   = edge_k + 1;
         idx = ((k - 1) / RD) % 4;
         ph  = (((k - 1) / RD) / BT) % 2;
`ifdef XDISPLAY_BLINK_EN
         off    = m_blank[idx] || (m_blink[idx] && ph == 1);
         e.busy = (ph == 1);
`else
         off    = m_blank[idx];
         e.busy = 1'b0;
`endif
         e.seg = off ? 7'h7F : HEX[m_val[idx]];
         e.an  = ~(4'b0001 << idx);
         for (int i = 0; i < 4; i++) begin
            if (s[i]) begin
               m_val[i]   = d[3:0];
               m_blank[i] = d[4];
               m_blink[i] = d[5];
            end
         end
         edge_k = k;
      end
      exp_q.push_back(e);
   endtask

   task automatic wait_an(input logic [3:0] target);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (an === target) begin
            ok = 1'b1;
            break;
         end
         cyc(1'b0, 4'h0, 6'h00);
      end
      chk("wait_an_reached", {31'b0, ok}, 32'd1);
   endtask

   always @(posedge clk) begin
      #1;
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         chk("sb_seg",  {25'b0, seg},  {25'b0, mon_e.seg});
         chk("sb_an",   {28'b0, an},   {28'b0, mon_e.an});
         chk("sb_busy", {31'b0, busy}, {31'b0, mon_e.busy});
      end
   end

   initial begin
      int idx;
      bit ok;
      rst         = 1'b1;
      bus.sel     = 4'h0;
      bus.data_in = '0;
      model_reset();

      repeat (3) cyc(1'b1, 4'h0, 6'h00);
      chk("rst_seg", {25'b0, seg}, 32'h7F);
      chk("rst_an",  {28'b0, an},  32'hF);

      cyc(1'b0, 4'h0, 6'h00);
      cyc(1'b0, 4'h0, 6'h00);
      chk("first_an",  {28'b0, an},  32'hE);
      chk("first_seg", {25'b0, seg}, 32'h7F);
      repeat (20) cyc(1'b0, 4'h0, 6'h00);

      cyc(1'b0, 4'b0001, 6'h08);
      cyc(1'b0, 4'h0, 6'h00);
      wait_an(4'b1110);
      chk("d0_eight", {25'b0, seg}, {25'b0, 7'b0000000});
      repeat (16) cyc(1'b0, 4'h0, 6'h00);

      cyc(1'b0, 4'b1111, 6'h0A);
      repeat (16) cyc(1'b0, 4'h0, 6'h00);
      cyc(1'b0, 4'b0100, 6'h10);
      cyc(1'b0, 4'h0, 6'h00);
      wait_an(4'b1011);
      chk("d2_blank", {25'b0, seg}, 32'h7F);
      wait_an(4'b0111);
      chk("d3_a", {25'b0, seg}, {25'b0, 7'b0001000});

      for (int i = 0; i < RD && ((edge_k + 1) % RD) != 0; i++) cyc(1'b0, 4'h0, 6'h00);
      idx = (edge_k / RD) % 4;
      cyc(1'b0, 4'(4'b0001 << idx), 6'h05);
      repeat (20) cyc(1'b0, 4'h0, 6'h00);

      for (int v = 0; v < 16; v++) begin
         cyc(1'b0, 4'b0001, 6'(v));
         repeat (3) cyc(1'b0, 4'h0, 6'h00);
      end

      repeat (5) cyc(1'b0, 4'h0, 6'h00);
      cyc(1'b1, 4'h0, 6'h00);
      cyc(1'b0, 4'h0, 6'h00);
      chk("mid_rst_seg", {25'b0, seg}, 32'h7F);
      chk("mid_rst_an",  {28'b0, an},  32'hF);
      cyc(1'b0, 4'h0, 6'h00);
      chk("restart_an", {28'b0, an}, 32'hE);
      repeat (20) cyc(1'b0, 4'h0, 6'h00);

      cyc(1'b0, 4'b0010, 6'h23);
      repeat (40) cyc(1'b0, 4'h0, 6'h00);
`ifdef XDISPLAY_BLINK_EN
      ok = 1'b0;
      for (int i = 0; i < 80; i++) begin
         if (busy === 1'b1 && an === 4'b1101) begin
            ok = 1'b1;
            break;
         end
         cyc(1'b0, 4'h0, 6'h00);
      end
      chk("blink_phase_seen", {31'b0, ok}, 32'd1);
      chk("blink_off_seg", {25'b0, seg}, 32'h7F);
`else
      wait_an(4'b1101);
      chk("d1_steady", {25'b0, seg}, {25'b0, 7'b0110000});
      chk("busy_low",  {31'b0, busy}, 32'd0);
`endif
      repeat (2) cyc(1'b0, 4'h0, 6'h00);
      @(posedge clk);
      #2;
      chk("sb_drained", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
